alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes and operand bundle shared by ALU, decoder and arbiter
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_JALR = 4'd10,
        ALU_THRU = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        alu_op_e         ctrl;
        logic            pc_sel;
        logic            imm_sel;
    } alu_operands_t;

    // All-zero bundle; ctrl encodes as ADD.
    localparam alu_operands_t ALU_OPS_RESET = '{
        rdata1:  '0,
        rdata2:  '0,
        pc:      '0,
        imm:     '0,
        ctrl:    ALU_ADD,
        pc_sel:  1'b0,
        imm_sel: 1'b0
    };

endpackage

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of one shared ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][31:0] req_rdata1,
    input  logic [1:0][31:0] req_rdata2,
    input  logic [1:0][31:0] req_pc,
    input  logic [1:0][31:0] req_imm,
    input  logic [1:0][3:0]  req_alu_ctrl,
    input  logic [1:0]       req_pc_sel,
    input  logic [1:0]       req_imm_sel,
    output logic [31:0]      alu_rdata1,
    output logic [31:0]      alu_rdata2,
    output logic [31:0]      alu_pc,
    output logic [31:0]      alu_imm,
    output logic [3:0]       alu_ctrl,
    output logic             alu_pc_sel,
    output logic             alu_imm_sel,
    input  logic [31:0]      alu_result,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0][31:0] rsp_result
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    localparam logic PRIO_RESET = 1'(RR_INIT);

    state_e          state_q, state_d;
    logic            prio_q, prio_d;
    logic            gnt_idx_q, gnt_idx_d;
    alu_operands_t   ops_q, ops_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] rsp_result_q, rsp_result_d;

    logic [1:0]      eligible;
    logic            grant;
    logic            grant_idx;

    // A buffer being drained this cycle still blocks its requester.
    always_comb begin
        eligible  = req_valid & ~rsp_valid_q;
        grant     = 1'b0;
        grant_idx = prio_q;
        if (rst_n && state_q == ST_IDLE) begin
            if (eligible[prio_q]) begin
                grant     = 1'b1;
                grant_idx = prio_q;
            end else if (eligible[~prio_q]) begin
                grant     = 1'b1;
                grant_idx = ~prio_q;
            end
        end
    end

    assign req_ready = grant ? (2'b01 << grant_idx) : 2'b00;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        gnt_idx_d    = gnt_idx_q;
        ops_d        = ops_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;

        for (int i = 0; i < 2; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    ops_d.rdata1  = req_rdata1[grant_idx];
                    ops_d.rdata2  = req_rdata2[grant_idx];
                    ops_d.pc      = req_pc[grant_idx];
                    ops_d.imm     = req_imm[grant_idx];
                    ops_d.ctrl    = alu_op_e'(req_alu_ctrl[grant_idx]);
                    ops_d.pc_sel  = req_pc_sel[grant_idx];
                    ops_d.imm_sel = req_imm_sel[grant_idx];
                    gnt_idx_d     = grant_idx;
                    prio_d        = ~grant_idx;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d[gnt_idx_q] = alu_result;
                rsp_valid_d[gnt_idx_q]  = 1'b1;
                state_d                 = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prio_q       <= PRIO_RESET;
            gnt_idx_q    <= 1'b0;
            ops_q        <= ALU_OPS_RESET;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            gnt_idx_q    <= gnt_idx_d;
            ops_q        <= ops_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_rdata1  = ops_q.rdata1;
    assign alu_rdata2  = ops_q.rdata2;
    assign alu_pc      = ops_q.pc;
    assign alu_imm     = ops_q.imm;
    assign alu_ctrl    = ops_q.ctrl;
    assign alu_pc_sel  = ops_q.pc_sel;
    assign alu_imm_sel = ops_q.imm_sel;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter with a behavioural ALU beside it
module tb_alu_arbiter;
    import alu_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_rdata1;
    logic [1:0][31:0] req_rdata2;
    logic [1:0][31:0] req_pc;
    logic [1:0][31:0] req_imm;
    logic [1:0][3:0]  req_alu_ctrl;
    logic [1:0]       req_pc_sel;
    logic [1:0]       req_imm_sel;
    logic [31:0]      alu_rdata1;
    logic [31:0]      alu_rdata2;
    logic [31:0]      alu_pc;
    logic [31:0]      alu_imm;
    logic [3:0]       alu_ctrl;
    logic             alu_pc_sel;
    logic             alu_imm_sel;
    logic [31:0]      alu_result;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_result;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_arbiter #(.RR_INIT(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rdata1   (req_rdata1),
        .req_rdata2   (req_rdata2),
        .req_pc       (req_pc),
        .req_imm      (req_imm),
        .req_alu_ctrl (req_alu_ctrl),
        .req_pc_sel   (req_pc_sel),
        .req_imm_sel  (req_imm_sel),
        .alu_rdata1   (alu_rdata1),
        .alu_rdata2   (alu_rdata2),
        .alu_pc       (alu_pc),
        .alu_imm      (alu_imm),
        .alu_ctrl     (alu_ctrl),
        .alu_pc_sel   (alu_pc_sel),
        .alu_imm_sel  (alu_imm_sel),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU that lives next to the arbiter.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] r1,
                                              input logic [31:0] r2, input logic [31:0] pc,
                                              input logic [31:0] imm, input logic ps,
                                              input logic is);
        logic [31:0] a;
        logic [31:0] b;
        a = ps ? pc : r1;
        b = is ? imm : r2;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a | b;
            4'd6:    return a & b;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'($signed(a) >>> b[4:0]);
            4'd10:   return (a + b) & 32'hFFFF_FFFE;
            4'd11:   return b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_model(alu_ctrl, alu_rdata1, alu_rdata2, alu_pc, alu_imm,
                               alu_pc_sel, alu_imm_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic r, input logic [3:0] op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] pc, input logic [31:0] imm,
                          input logic ps, input logic is);
        req_alu_ctrl[r] = op;
        req_rdata1[r]   = r1;
        req_rdata2[r]   = r2;
        req_pc[r]       = pc;
        req_imm[r]      = imm;
        req_pc_sel[r]   = ps;
        req_imm_sel[r]  = is;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ps;
        logic        is;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, ALU_ADD,  32'd5,         32'd7,         32'd0,       32'd0,    1'b0, 1'b0, 32'd12};
        vecs[1] = '{1'b1, ALU_JALR, 32'h0000_DEAD, 32'h0000_BEEF, 32'h1000,    32'h7,    1'b1, 1'b1, 32'h1006};
        vecs[2] = '{1'b0, ALU_SUB,  32'd10,        32'd3,         32'd0,       32'd0,    1'b0, 1'b0, 32'd7};
        vecs[3] = '{1'b1, ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd0,       32'd0,    1'b0, 1'b0, 32'd1};
        vecs[4] = '{1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,       32'd0,    1'b0, 1'b0, 32'd0};
        vecs[5] = '{1'b1, ALU_SRA,  32'h8000_0000, 32'd4,         32'd0,       32'd0,    1'b0, 1'b0, 32'hF800_0000};
        vecs[6] = '{1'b0, ALU_SLL,  32'd1,         32'd31,        32'd0,       32'd0,    1'b0, 1'b0, 32'h8000_0000};
        vecs[7] = '{1'b0, ALU_THRU, 32'd1,         32'd9,         32'd0,       32'h55,   1'b0, 1'b1, 32'h55};
        vecs[8] = '{1'b1, ALU_OR,   32'hF0,        32'h0F,        32'd0,       32'd0,    1'b0, 1'b0, 32'hFF};

        rst_n        = 1'b0;
        req_valid    = 2'b11;
        rsp_ready    = 2'b00;
        req_rdata1   = '0;
        req_rdata2   = '0;
        req_pc       = '0;
        req_imm      = '0;
        req_alu_ctrl = '0;
        req_pc_sel   = '0;
        req_imm_sel  = '0;
        tick();
        tick();

        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_result0", rsp_result[0], 32'd0);
        chk("reset_rsp_result1", rsp_result[1], 32'd0);
        chk("reset_alu_ops", alu_rdata1 | alu_rdata2 | alu_pc | alu_imm, 32'd0);
        chk("reset_alu_ctrl", {26'd0, alu_pc_sel, alu_imm_sel, alu_ctrl}, 32'd0);

        // Both requesters contend right after reset; priority starts at requester 0.
        rst_n = 1'b1;
        set_op(1'b0, ALU_SUB, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        set_op(1'b1, ALU_XOR, 32'hF0, 32'hFF, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("both_first_grant", {30'd0, req_ready}, 32'd1);
        tick();
        chk("both_exec_ready", {30'd0, req_ready}, 32'd0);
        tick();
        chk("both_rsp0_valid", {30'd0, rsp_valid}, 32'd1);
        chk("both_rsp0_result", rsp_result[0], 32'd7);
        chk("both_second_grant", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        chk("both_rsp_valid", {30'd0, rsp_valid}, 32'd3);
        chk("both_rsp1_result", rsp_result[1], 32'h0F);
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        chk("both_drained", {30'd0, rsp_valid}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            set_op(vecs[v].r, vecs[v].op, vecs[v].r1, vecs[v].r2, vecs[v].pc, vecs[v].imm,
                   vecs[v].ps, vecs[v].is);
            req_valid = 2'b01 << vecs[v].r;
            #1;
            chk($sformatf("vec%0d_ready", v), {30'd0, req_ready}, {30'd0, 2'b01 << vecs[v].r});
            tick();
            req_valid = 2'b00;
            set_op(vecs[v].r, ALU_AND, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 1'b1, 1'b1);
            #1;
            chk($sformatf("vec%0d_exec_ready", v), {30'd0, req_ready}, 32'd0);
            chk($sformatf("vec%0d_alu_ctrl", v), {28'd0, alu_ctrl}, {28'd0, vecs[v].op});
            tick();
            chk($sformatf("vec%0d_rsp_valid", v), {30'd0, rsp_valid}, {30'd0, 2'b01 << vecs[v].r});
            chk($sformatf("vec%0d_result", v), rsp_result[vecs[v].r], vecs[v].exp);
            rsp_ready = 2'b01 << vecs[v].r;
            tick();
            rsp_ready = 2'b00;
            chk($sformatf("vec%0d_drained", v), {30'd0, rsp_valid}, 32'd0);
        end

        // Undrained result on requester 0 blocks it while requester 1 keeps being served.
        set_op(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        chk("block_rsp0_result", rsp_result[0], 32'd12);
        set_op(1'b0, ALU_SUB, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_op(1'b1, ALU_ADD, 32'(k), 32'd100, 32'd0, 32'd0, 1'b0, 1'b0);
            #1;
            chk($sformatf("block%0d_ready", k), {30'd0, req_ready}, 32'd2);
            tick();
            chk($sformatf("block%0d_exec_ready", k), {30'd0, req_ready}, 32'd0);
            tick();
            chk($sformatf("block%0d_full_ready", k), {30'd0, req_ready}, 32'd0);
            chk($sformatf("block%0d_rsp_valid", k), {30'd0, rsp_valid}, 32'd3);
            chk($sformatf("block%0d_rsp1", k), rsp_result[1], 32'd100 + 32'(k));
            chk($sformatf("block%0d_rsp0_hold", k), rsp_result[0], 32'd12);
            rsp_ready = 2'b10;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;

        // Reset pulsed mid-EXEC drops the in-flight op and restores priority.
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        set_op(1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("rst_pre_grant", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_mid_alu_ops", alu_rdata1 | alu_rdata2, 32'd0);
        chk("rst_mid_ready", {30'd0, req_ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_post_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_post_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        set_op(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("rst_post_prio", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
